// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing totals helpers and standard mode presets
package vga_timing_pkg;

    typedef struct packed {
        int   pixel_mhz;
        int   h_active;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_active;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_sync_pol;
        logic v_sync_pol;
    } vga_mode_t;

    function automatic int h_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic int v_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam vga_mode_t VGA_640x480_60 = '{
        pixel_mhz: 25,
        h_active: 640, h_front: 16, h_sync: 96,  h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,   v_back: 33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    localparam vga_mode_t SVGA_800x600_72 = '{
        pixel_mhz: 50,
        h_active: 800, h_front: 56, h_sync: 120, h_back: 64,
        v_active: 600, v_front: 37, v_sync: 6,   v_back: 23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };

endpackage

// File: rtl/pixel_clk_en_gen.sv
// rtl/pixel_clk_en_gen.sv - divide-by-div clock enable strobe plus ~50% duty divided clock
module pixel_clk_en_gen #(
    parameter int div = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pixel_en,
    output logic pixel_clk
);

    localparam int W = (div > 1) ? $clog2(div) : 1;
    localparam logic [W-1:0] LAST = W'(div - 1);
    localparam logic [W-1:0] HALF = W'(div / 2);

    logic [W-1:0] div_cnt;
    logic [W-1:0] div_nxt;

    always_comb begin
        div_nxt = div_cnt;
        if (en) begin
            div_nxt = (div_cnt == LAST) ? '0 : div_cnt + W'(1);
        end
    end

    assign pixel_en = en && (div_cnt == LAST);

    // pixel_clk follows the next count so it lines up with the divider phase
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            pixel_clk <= (div > 1);
        end else begin
            div_cnt   <= div_nxt;
            pixel_clk <= (div_nxt < HALF);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing: x/y, syncs, blanking, line/frame pulses
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   clk_mhz    = 50,
    parameter int   pixel_mhz  = 25,
    parameter int   h_active   = 640,
    parameter int   h_front    = 16,
    parameter int   h_sync     = 96,
    parameter int   h_back     = 48,
    parameter int   v_active   = 480,
    parameter int   v_front    = 10,
    parameter int   v_sync     = 2,
    parameter int   v_back     = 33,
    parameter logic h_sync_pol = 1'b0,
    parameter logic v_sync_pol = 1'b0,
    parameter int   w_frame    = 8,
    parameter int   w_x        = $clog2(h_total(h_active, h_front, h_sync, h_back)),
    parameter int   w_y        = $clog2(v_total(v_active, v_front, v_sync, v_back))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pixel_en,
    output logic               pixel_clk,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [w_x-1:0]     x,
    output logic [w_y-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic [w_frame-1:0] frame_cnt
);

    localparam int DIV     = (pixel_mhz > 0) ? clk_mhz / pixel_mhz : 0;
    localparam int H_TOTAL = h_total(h_active, h_front, h_sync, h_back);
    localparam int V_TOTAL = v_total(v_active, v_front, v_sync, v_back);
    localparam logic [w_x-1:0] H_LAST = w_x'(H_TOTAL - 1);
    localparam logic [w_y-1:0] V_LAST = w_y'(V_TOTAL - 1);

    if (pixel_mhz < 1 || DIV < 1 || (clk_mhz % pixel_mhz) != 0) begin : g_bad_div
        $error("vga_timing_gen: clk_mhz must be an integer multiple of pixel_mhz");
    end

    logic [w_x-1:0] hpos, hpos_nxt;
    logic [w_y-1:0] vpos, vpos_nxt;
    logic           wrap_to_origin;

    pixel_clk_en_gen #(.div(DIV)) u_pixel_clk_en_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pixel_en  (pixel_en),
        .pixel_clk (pixel_clk)
    );

    always_comb begin
        hpos_nxt = hpos;
        vpos_nxt = vpos;
        if (pixel_en) begin
            if (hpos == H_LAST) begin
                hpos_nxt = '0;
                vpos_nxt = (vpos == V_LAST) ? '0 : vpos + w_y'(1);
            end else begin
                hpos_nxt = hpos + w_x'(1);
            end
        end
    end

    assign wrap_to_origin = pixel_en && (hpos_nxt == '0) && (vpos_nxt == '0);

    // Outputs are derived from the next counters so x/y and syncs switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            frame_cnt   <= '0;
            display_on  <= 1'b0;
            hsync       <= ~h_sync_pol;
            vsync       <= ~v_sync_pol;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            display_on  <= (int'(hpos_nxt) < h_active) && (int'(vpos_nxt) < v_active);
            hsync       <= ((int'(hpos_nxt) >= h_active + h_front) &&
                            (int'(hpos_nxt) <  h_active + h_front + h_sync)) ? h_sync_pol : ~h_sync_pol;
            vsync       <= ((int'(vpos_nxt) >= v_active + v_front) &&
                            (int'(vpos_nxt) <  v_active + v_front + v_sync)) ? v_sync_pol : ~v_sync_pol;
            line_start  <= pixel_en && (hpos_nxt == '0);
            frame_start <= wrap_to_origin;
            if (wrap_to_origin) begin
                frame_cnt <= frame_cnt + w_frame'(1);
            end
        end
    end

    assign x = hpos;
    assign y = vpos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen across three timing configurations
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    localparam int HA[3]  = '{8, 6, 800};
    localparam int HF[3]  = '{2, 1, 56};
    localparam int HS[3]  = '{3, 2, 120};
    localparam int HB[3]  = '{2, 1, 64};
    localparam int VA[3]  = '{6, 4, 600};
    localparam int VF[3]  = '{1, 1, 37};
    localparam int VS[3]  = '{2, 1, 6};
    localparam int VB[3]  = '{2, 1, 23};
    localparam int HP[3]  = '{0, 1, 1};
    localparam int VP[3]  = '{0, 0, 1};
    localparam int DV[3]  = '{2, 3, 1};
    localparam int WF[3]  = '{8, 2, 8};

    logic [3:0]  x_a, y_a;   logic [7:0] fc_a;
    logic [3:0]  x_b;        logic [2:0] y_b;  logic [1:0] fc_b;
    logic [10:0] x_c;        logic [9:0] y_c;  logic [7:0] fc_c;
    logic pe[3], pc[3], hs[3], vs[3], dp[3], ls[3], fs[3];
    logic [31:0] ox[3], oy[3], fc[3];

    vga_timing_gen #(
        .clk_mhz(50), .pixel_mhz(25), .h_active(8), .h_front(2), .h_sync(3), .h_back(2),
        .v_active(6), .v_front(1), .v_sync(2), .v_back(2), .h_sync_pol(1'b0), .v_sync_pol(1'b0), .w_frame(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .pixel_en(pe[0]), .pixel_clk(pc[0]), .hsync(hs[0]), .vsync(vs[0]),
        .display_on(dp[0]), .x(x_a), .y(y_a), .line_start(ls[0]), .frame_start(fs[0]), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .clk_mhz(75), .pixel_mhz(25), .h_active(6), .h_front(1), .h_sync(2), .h_back(1),
        .v_active(4), .v_front(1), .v_sync(1), .v_back(1), .h_sync_pol(1'b1), .v_sync_pol(1'b0), .w_frame(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .pixel_en(pe[1]), .pixel_clk(pc[1]), .hsync(hs[1]), .vsync(vs[1]),
        .display_on(dp[1]), .x(x_b), .y(y_b), .line_start(ls[1]), .frame_start(fs[1]), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .clk_mhz(50), .pixel_mhz(SVGA_800x600_72.pixel_mhz),
        .h_active(SVGA_800x600_72.h_active), .h_front(SVGA_800x600_72.h_front),
        .h_sync(SVGA_800x600_72.h_sync), .h_back(SVGA_800x600_72.h_back),
        .v_active(SVGA_800x600_72.v_active), .v_front(SVGA_800x600_72.v_front),
        .v_sync(SVGA_800x600_72.v_sync), .v_back(SVGA_800x600_72.v_back),
        .h_sync_pol(SVGA_800x600_72.h_sync_pol), .v_sync_pol(SVGA_800x600_72.v_sync_pol), .w_frame(8)
    ) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .pixel_en(pe[2]), .pixel_clk(pc[2]), .hsync(hs[2]), .vsync(vs[2]),
        .display_on(dp[2]), .x(x_c), .y(y_c), .line_start(ls[2]), .frame_start(fs[2]), .frame_cnt(fc_c)
    );

    assign ox[0] = 32'(x_a);  assign oy[0] = 32'(y_a);  assign fc[0] = 32'(fc_a);
    assign ox[1] = 32'(x_b);  assign oy[1] = 32'(y_b);  assign fc[1] = 32'(fc_b);
    assign ox[2] = 32'(x_c);  assign oy[2] = 32'(y_c);  assign fc[2] = 32'(fc_c);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int   k;
        int   x, y, fc;
        logic pc, hs, vs, dp, ls, fs;
    } exp_t;

    exp_t q[$];
    int   ph[3], idx[3], fcm[3];
    logic lsm[3], fsm[3];
    bit   valid = 1'b0;

    // Reference: a linear pixel index over the frame plus a divider phase
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int   ht, n, px, py;
            exp_t e;
            ht = HA[k] + HF[k] + HS[k] + HB[k];
            n  = ht * (VA[k] + VF[k] + VS[k] + VB[k]);
            if (rst) begin
                ph[k] = 0; idx[k] = n - 1; fcm[k] = 0; lsm[k] = 0; fsm[k] = 0;
                valid = 1'b1;
            end else if (en && ph[k] == DV[k] - 1) begin
                ph[k]  = 0;
                idx[k] = (idx[k] + 1) % n;
                lsm[k] = (idx[k] % ht == 0);
                fsm[k] = (idx[k] == 0);
                if (fsm[k]) fcm[k] = (fcm[k] + 1) % (1 << WF[k]);
            end else begin
                if (en) ph[k] = ph[k] + 1;
                lsm[k] = 0; fsm[k] = 0;
            end
            if (valid) begin
                px = idx[k] % ht;
                py = idx[k] / ht;
                e.k  = k;  e.x = px;  e.y = py;  e.fc = fcm[k];
                e.pc = (ph[k] < DV[k] / 2);
                e.dp = (px < HA[k]) && (py < VA[k]);
                e.hs = (px >= HA[k] + HF[k] && px < HA[k] + HF[k] + HS[k]) ? HP[k][0] : !HP[k][0];
                e.vs = (py >= VA[k] + VF[k] && py < VA[k] + VF[k] + VS[k]) ? VP[k][0] : !VP[k][0];
                e.ls = lsm[k];  e.fs = fsm[k];
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("d%0d.x", e.k),           ox[e.k], e.x);
            check($sformatf("d%0d.y", e.k),           oy[e.k], e.y);
            check($sformatf("d%0d.frame_cnt", e.k),   fc[e.k], e.fc);
            check($sformatf("d%0d.pixel_clk", e.k),   pc[e.k], e.pc);
            check($sformatf("d%0d.display_on", e.k),  dp[e.k], e.dp);
            check($sformatf("d%0d.hsync", e.k),       hs[e.k], e.hs);
            check($sformatf("d%0d.vsync", e.k),       vs[e.k], e.vs);
            check($sformatf("d%0d.line_start", e.k),  ls[e.k], e.ls);
            check($sformatf("d%0d.frame_start", e.k), fs[e.k], e.fs);
        end
        if (valid) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("d%0d.pixel_en", k), pe[k], int'(en && ph[k] == DV[k] - 1));
            end
        end
    end

    task automatic wait_xy(input int k, input int wx, input int wy, input string tag);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ox[k] == wx && oy[k] == wy) break;
        end
        check({tag, ".reached"}, int'(i < 5000), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input int k, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!fs[k] && cycles < limit);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        wait_pulse(0, 10, lat);
        check("a.first_frame_start_latency", lat, 2);
        check("a.first_x", ox[0], 0);
        check("a.first_y", oy[0], 0);
        check("a.first_display_on", dp[0], 1);
        check("a.first_frame_cnt", fc[0], 1);

        wait_xy(0, 5, 3, "freeze");
        en = 1'b0;
        repeat (37) @(posedge clk);
        #2 en = 1'b1;

        repeat (400) begin
            @(posedge clk);
            #2 en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;

        wait_xy(0, 10, 4, "midreset");
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("a.reset_x", ox[0], 14);
        check("a.reset_y", oy[0], 10);
        check("a.reset_hsync", hs[0], 1);
        check("a.reset_display_on", dp[0], 0);
        check("a.reset_pixel_clk", pc[0], 1);
        check("c.reset_pixel_clk", pc[2], 0);

        for (int f = 0; f < 5; f++) begin
            wait_pulse(1, 1000, lat);
            check($sformatf("b.frame_cnt_seq%0d", f), fc[1], (f + 1) % 4);
        end

        wait_pulse(0, 2000, lat);
        wait_pulse(0, 2000, lat);
        check("a.frame_period", lat, 330);

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
